// File: rtl/mult_ctrl.sv
// Iterative shift-add multiplier with HI/LO result registers.
// Signed operands are multiplied as magnitudes and sign-corrected at the end.
module mult_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             mult_sign,
    input  logic [WIDTH-1:0] srca_e,
    input  logic [WIDTH-1:0] srcb_e,
    input  logic             hilo_read_d,
    output logic             busy,
    output logic             done,
    output logic             stall_hilo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t               state;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   acc;
    logic [CW-1:0]        cnt;
    logic                 neg;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   fixed;

    // The most negative value negates to itself, which is its correct unsigned magnitude.
    always_comb begin
        mag_a = srca_e;
        mag_b = srcb_e;
        if (mult_sign && srca_e[WIDTH-1]) mag_a = -srca_e;
        if (mult_sign && srcb_e[WIDTH-1]) mag_b = -srcb_e;
    end

    always_comb begin
        sum = {1'b0, acc[2*WIDTH-1:WIDTH]};
        if (mplier[0]) sum = sum + {1'b0, mcand};
        fixed = neg ? -acc : acc;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_mult) begin
                        mcand  <= mag_a;
                        mplier <= mag_b;
                        neg    <= mult_sign & (srca_e[WIDTH-1] ^ srcb_e[WIDTH-1]);
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc    <= {sum, acc[WIDTH-1:1]};
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) state <= FIX;
                end
                FIX: begin
                    {hi, lo} <= fixed;
                    done     <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy       = (state != IDLE);
    assign stall_hilo = busy & hilo_read_d;
endmodule

// File: tb/tb_mult_ctrl.sv
// Self-checking bench for mult_ctrl: directed vectors, back-to-back,
// ignored restart, mid-run reset and randomized operands vs an arithmetic model.
module tb_mult_ctrl;
    localparam int W = 32;
    localparam int LAT = W + 1;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start_mult = 1'b0;
    logic         mult_sign = 1'b0;
    logic [W-1:0] srca_e = '0;
    logic [W-1:0] srcb_e = '0;
    logic         hilo_read_d = 1'b0;
    logic         busy, done, stall_hilo;
    logic [W-1:0] hi, lo;

    int passed = 0;
    int total = 0;
    logic [2*W-1:0] prev;

    typedef struct {
        logic         sign;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
    } vec_t;

    vec_t vecs[8];

    mult_ctrl #(.WIDTH(W)) dut (
        .clk(clk),
        .reset(reset),
        .start_mult(start_mult),
        .mult_sign(mult_sign),
        .srca_e(srca_e),
        .srcb_e(srcb_e),
        .hilo_read_d(hilo_read_d),
        .busy(busy),
        .done(done),
        .stall_hilo(stall_hilo),
        .hi(hi),
        .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [63:0] ref_prod(input logic s, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        longint sa, sb;
        longint unsigned ua, ub;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'b0, a};
        ub = {32'b0, b};
        return ua * ub;
    endfunction

    // Entered at a negedge; returns at the negedge where done is high, or after reset recovery.
    task automatic run_seq(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [63:0] exp, input bit inject, input int abort_at);
        logic expb;
        mult_sign  = s;
        srca_e     = a;
        srcb_e     = b;
        start_mult = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= LAT; k++) begin
            @(negedge clk);
            expb = (k < LAT);
            check("busy", 64'(busy), 64'(expb));
            check("done", 64'(done), 64'(k == LAT));
            check("stall", 64'(stall_hilo), 64'(expb & hilo_read_d));
            check("hilo", {hi, lo}, (k == LAT) ? exp : prev);
            if (k == LAT) begin
                check("hilo_ref", {hi, lo}, ref_prod(s, a, b));
                prev = exp;
                return;
            end
            if (k == abort_at) begin
                reset = 1'b0;
                #1;
                check("rst_busy", 64'(busy), 64'd0);
                check("rst_done", 64'(done), 64'd0);
                check("rst_hilo", {hi, lo}, 64'd0);
                check("rst_stall", 64'(stall_hilo), 64'd0);
                prev = '0;
                start_mult = 1'b0;
                @(negedge clk);
                @(negedge clk);
                reset = 1'b1;
                return;
            end
            start_mult = inject && (k == 9);
            if (start_mult) begin
                mult_sign = ~s;
                srca_e    = $urandom;
                srcb_e    = $urandom;
            end
            hilo_read_d = 1'($urandom);
        end
    endtask

    initial begin
        vecs[0] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1] = '{1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[2] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[3] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        vecs[4] = '{1'b0, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
        vecs[5] = '{1'b1, 32'h0000_0000, 32'hFFFF_FFF9, 32'h0000_0000, 32'h0000_0000};
        vecs[6] = '{1'b0, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000};
        vecs[7] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000};
        prev = '0;

        #3;
        check("init_busy", 64'(busy), 64'd0);
        check("init_done", 64'(done), 64'd0);
        check("init_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Back-to-back: each start is driven in the done cycle of the previous one.
        for (int i = 0; i < 8; i++)
            run_seq(vecs[i].sign, vecs[i].a, vecs[i].b,
                    {vecs[i].exp_hi, vecs[i].exp_lo}, i == 2, -1);
        start_mult = 1'b0;

        hilo_read_d = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            check("idle_busy", 64'(busy), 64'd0);
            check("idle_stall", 64'(stall_hilo), 64'd0);
            check("idle_done", 64'(done), 64'd0);
            check("idle_hilo", {hi, lo}, prev);
        end

        run_seq(1'b0, 32'hDEAD_BEEF, 32'h1234_5678, ref_prod(1'b0, 32'hDEAD_BEEF, 32'h1234_5678), 0, 15);
        check("post_rst_hilo", {hi, lo}, 64'd0);
        run_seq(1'b1, 32'hFFFF_FFFD, 32'h0000_0005, {32'hFFFF_FFFF, 32'hFFFF_FFF1}, 0, -1);

        for (int i = 0; i < 20; i++) begin
            logic s;
            logic [W-1:0] a, b;
            s = 1'($urandom);
            a = $urandom;
            b = $urandom;
            if (i % 7 == 3) a = 32'h8000_0000;
            if (i % 9 == 4) b = '0;
            run_seq(s, a, b, ref_prod(s, a, b), i % 5 == 1, -1);
            start_mult = 1'b0;
            if (i % 4 == 0) @(negedge clk);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
